// File: rtl/a23_trace_pkg.sv
// Shared types and constants for the A23 trace capture stage.
package a23_trace_pkg;

  // Bit positions inside the 4-bit record flag field.
  localparam int unsigned FLAG_EXE  = 0;
  localparam int unsigned FLAG_MEM  = 1;
  localparam int unsigned FLAG_WR   = 2;
  localparam int unsigned FLAG_DROP = 3;

  localparam int unsigned REC_W = 136;

  // One trace record as stored in the FIFO.
  typedef struct packed {
    logic [3:0]  flags;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } a23_trace_rec_t;

  // Builds a record from the raw strobes; fields of an inactive class are zeroed.
  function automatic a23_trace_rec_t build_rec(
    input logic        exe,
    input logic        mem,
    input logic        wr_en,
    input logic        drop,
    input logic [31:0] pc,
    input logic [31:0] instr,
    input logic [31:0] addr,
    input logic [31:0] wdata,
    input logic [31:0] rdata,
    input logic [3:0]  be
  );
    a23_trace_rec_t r;
    logic           wr;
    r  = '0;
    wr = mem & wr_en;
    r.flags[FLAG_EXE]  = exe;
    r.flags[FLAG_MEM]  = mem;
    r.flags[FLAG_WR]   = wr;
    r.flags[FLAG_DROP] = drop;
    if (exe) begin
      r.pc    = pc;
      r.instr = instr;
    end else begin
      r.pc    = 32'h0000_0000;
      r.instr = 32'h0000_0000;
    end
    if (mem) begin
      r.addr = addr;
      r.data = wr ? wdata : rdata;
      r.be   = be;
    end else begin
      r.addr = 32'h0000_0000;
      r.data = 32'h0000_0000;
      r.be   = 4'h0;
    end
    return r;
  endfunction

endpackage

// File: rtl/a23_trace_fifo.sv
// Generic synchronous FIFO; pointers carry one extra wrap bit so that
// full and empty are told apart without a separate counter.
module a23_trace_fifo #(
  parameter int unsigned WIDTH = 136,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push_s;
  logic             do_pop_s;

  assign o_empty   = (wr_ptr_q == rd_ptr_q);
  assign o_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign o_count   = wr_ptr_q - rd_ptr_q;
  assign o_rdata   = mem_q[rd_ptr_q[AW-1:0]];
  // Pops on empty are ignored; a push into a full FIFO needs a same-cycle pop.
  assign do_pop_s  = i_pop & ~o_empty;
  assign do_push_s = i_push & (~o_full | do_pop_s);

  // Next-state pointer arithmetic.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers; reset empties the FIFO immediately.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset because empty masks them.
  always_ff @(posedge i_clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= i_wdata;
    end
  end

endmodule

// File: rtl/a23_trace_capture.sv
// Non-intrusive A23 trace capture: packs each execute/data-access cycle into
// one record, buffers it, and counts records lost to a full FIFO instead of
// ever stalling the core.
module a23_trace_capture
  import a23_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_enable,
  input  logic                     i_clr,
  input  logic                     i_fetch_stall,
  input  logic                     i_instruction_execute,
  input  logic [31:0]              i_instruction,
  input  logic [31:0]              i_instruction_address,
  input  logic                     i_data_access,
  input  logic                     i_write_enable,
  input  logic [31:0]              i_address,
  input  logic [31:0]              i_write_data,
  input  logic [3:0]               i_byte_enable,
  input  logic [31:0]              i_read_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [3:0]               o_flags,
  output logic [31:0]              o_pc,
  output logic [31:0]              o_instr,
  output logic [31:0]              o_addr,
  output logic [31:0]              o_data,
  output logic [3:0]               o_be,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  output logic [CNT_W-1:0]         o_drop_cnt
);

  logic             event_s;
  logic             pop_s;
  logic             accept_s;
  logic             drop_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [REC_W-1:0] head_raw_s;
  a23_trace_rec_t   rec_s;
  a23_trace_rec_t   head_s;

  logic             overflow_q, overflow_d;
  logic             pend_drop_q, pend_drop_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  assign event_s  = i_enable & ~i_fetch_stall & (i_instruction_execute | i_data_access);
  assign pop_s    = o_valid & i_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign accept_s = event_s & (~fifo_full_s | pop_s);
  assign drop_s   = event_s & ~accept_s;
  assign rec_s    = build_rec(i_instruction_execute, i_data_access, i_write_enable,
                              pend_drop_q, i_instruction_address, i_instruction,
                              i_address, i_write_data, i_read_data, i_byte_enable);
  assign head_s   = head_raw_s;
  assign o_valid  = ~fifo_empty_s;

  a23_trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (accept_s),
    .i_wdata (rec_s),
    .i_pop   (pop_s),
    .o_rdata (head_raw_s),
    .o_full  (fifo_full_s),
    .o_empty (fifo_empty_s),
    .o_count (o_count)
  );

  // Unpack the head entry; an empty FIFO presents all-zero fields.
  always_comb begin
    o_flags = 4'h0;
    o_pc    = 32'h0000_0000;
    o_instr = 32'h0000_0000;
    o_addr  = 32'h0000_0000;
    o_data  = 32'h0000_0000;
    o_be    = 4'h0;
    if (o_valid) begin
      o_flags = head_s.flags;
      o_pc    = head_s.pc;
      o_instr = head_s.instr;
      o_addr  = head_s.addr;
      o_data  = head_s.data;
      o_be    = head_s.be;
    end else begin
      o_flags = 4'h0;
    end
  end

  // Drop bookkeeping; a clear pulse beats a same-cycle drop.
  always_comb begin
    overflow_d  = overflow_q;
    pend_drop_d = pend_drop_q;
    drop_cnt_d  = drop_cnt_q;
    if (i_clr) begin
      overflow_d  = 1'b0;
      pend_drop_d = 1'b0;
      drop_cnt_d  = {CNT_W{1'b0}};
    end else if (drop_s) begin
      overflow_d  = 1'b1;
      pend_drop_d = 1'b1;
      if (drop_cnt_q != {CNT_W{1'b1}}) begin
        drop_cnt_d = drop_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end else if (accept_s) begin
      pend_drop_d = 1'b0;
    end else begin
      pend_drop_d = pend_drop_q;
    end
  end

  // Drop bookkeeping registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      overflow_q  <= 1'b0;
      pend_drop_q <= 1'b0;
      drop_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      overflow_q  <= overflow_d;
      pend_drop_q <= pend_drop_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign o_overflow = overflow_q;
  assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_a23_trace_capture.sv
// Scoreboard bench for a23_trace_capture: stimulus queues hand-computed
// records, a monitor compares them against every handshaken output.
module tb_a23_trace_capture;
  import a23_trace_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = 16;

  logic        i_clk = 1'b0;
  logic        i_rst, i_enable, i_clr, i_fetch_stall;
  logic        i_instruction_execute, i_data_access, i_write_enable;
  logic [31:0] i_instruction, i_instruction_address, i_address, i_write_data, i_read_data;
  logic [3:0]  i_byte_enable;
  logic        o_valid, i_ready;
  logic [3:0]  o_flags, o_be;
  logic [31:0] o_pc, o_instr, o_addr, o_data;
  logic [4:0]  o_count;
  logic        o_overflow;
  logic [15:0] o_drop_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  a23_trace_rec_t exp_q[$];

  a23_trace_capture #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_clr(i_clr),
    .i_fetch_stall(i_fetch_stall), .i_instruction_execute(i_instruction_execute),
    .i_instruction(i_instruction), .i_instruction_address(i_instruction_address),
    .i_data_access(i_data_access), .i_write_enable(i_write_enable),
    .i_address(i_address), .i_write_data(i_write_data), .i_byte_enable(i_byte_enable),
    .i_read_data(i_read_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_flags(o_flags), .o_pc(o_pc), .o_instr(o_instr), .o_addr(o_addr),
    .o_data(o_data), .o_be(o_be), .o_count(o_count), .o_overflow(o_overflow),
    .o_drop_cnt(o_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  function automatic void chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic a23_trace_rec_t mk(input logic [3:0] f, input logic [31:0] pc, input logic [31:0] ins,
                                        input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    a23_trace_rec_t r;
    r.flags = f; r.pc = pc; r.instr = ins; r.addr = a; r.data = d; r.be = be;
    return r;
  endfunction

  // Monitor: every accepted head record must match the oldest expected one.
  always @(negedge i_clk) begin
    if (o_valid === 1'b1 && i_ready === 1'b1 && i_rst === 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rec", {o_flags, o_pc, o_instr, o_addr, o_data, o_be}, 136'h0);
      end else begin
        chk("rec", {o_flags, o_pc, o_instr, o_addr, o_data, o_be}, exp_q.pop_front());
      end
    end
  end

  // Watchdog: the run must never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_instruction_execute = 1'b0; i_data_access = 1'b0; i_write_enable = 1'b0;
    i_instruction = 32'h0; i_instruction_address = 32'h0; i_address = 32'h0;
    i_write_data = 32'h0; i_read_data = 32'h0; i_byte_enable = 4'h0; i_fetch_stall = 1'b0;
  endtask

  // One retire cycle; exp_push/exp_flags are the hand-predicted outcome.
  task automatic retire(input logic [31:0] pc, input logic [31:0] ins, input bit exp_push, input logic [3:0] exp_flags);
    i_instruction_execute = 1'b1; i_instruction_address = pc; i_instruction = ins;
    if (exp_push) exp_q.push_back(mk(exp_flags, pc, ins, 32'h0, 32'h0, 4'h0));
    step();
    idle();
  endtask

  task automatic drain();
    i_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (o_count == 5'd0) break;
      step();
    end
    chk("drain_count", o_count, 136'd0);
  endtask

  initial begin
    idle();
    i_rst = 1'b1; i_enable = 1'b1; i_clr = 1'b0; i_ready = 1'b0;
    step(); step();
    i_rst = 1'b0;
    chk("rst_valid", o_valid, 136'd0);
    chk("rst_count", o_count, 136'd0);
    chk("rst_ovf_drop", {o_overflow, o_drop_cnt}, 136'd0);
    chk("rst_fields", {o_flags, o_pc, o_instr, o_addr, o_data, o_be}, 136'd0);

    // Single retire, one-cycle latency, popped the next cycle.
    i_ready = 1'b1;
    retire(32'h100, 32'hE3A00001, 1'b1, 4'b0001);
    chk("t1_valid", o_valid, 136'd1);
    chk("t1_flags", o_flags, 136'h1);
    chk("t1_pc", o_pc, 136'h100);
    step();
    chk("t1_valid_after", o_valid, 136'd0);

    // Retire and write in the same cycle form one record.
    i_instruction_execute = 1'b1; i_instruction_address = 32'h104; i_instruction = 32'hE5801000;
    i_data_access = 1'b1; i_write_enable = 1'b1; i_address = 32'h2000;
    i_write_data = 32'hDEADBEEF; i_read_data = 32'h12345678; i_byte_enable = 4'hF;
    exp_q.push_back(mk(4'b0111, 32'h104, 32'hE5801000, 32'h2000, 32'hDEADBEEF, 4'hF));
    step();
    idle();
    chk("t2_count", o_count, 136'd1);
    chk("t2_flags", o_flags, 136'h7);
    chk("t2_addr_data", {o_addr, o_data}, {104'h0, 32'h2000, 32'hDEADBEEF});
    step();
    chk("t2_single", o_count, 136'd0);

    // Stalled read captured only once the stall lifts.
    i_data_access = 1'b1; i_address = 32'h3000; i_byte_enable = 4'hF;
    i_read_data = 32'h11; i_fetch_stall = 1'b1;
    step(); step(); step();
    chk("t3_stall_count", o_count, 136'd0);
    i_fetch_stall = 1'b0; i_read_data = 32'h55;
    exp_q.push_back(mk(4'b0010, 32'h0, 32'h0, 32'h3000, 32'h55, 4'hF));
    step();
    idle();
    chk("t3_flags", o_flags, 136'h2);
    chk("t3_data", o_data, 136'h55);
    step();
    chk("t3_single", o_count, 136'd0);

    // Disabled capture: no push.
    i_enable = 1'b0;
    retire(32'h180, 32'hE1A00000, 1'b0, 4'b0000);
    chk("dis_count", o_count, 136'd0);
    i_enable = 1'b1;

    // Overflow: 20 retires into a stalled consumer, 4 dropped.
    i_ready = 1'b0;
    for (int k = 0; k < 20; k++)
      retire(32'h200 + 32'(4*k), 32'hE1A00000 + 32'(k), (k < 16), 4'b0001);
    chk("t4_count", o_count, 136'd16);
    chk("t4_drop_cnt", o_drop_cnt, 136'd4);
    chk("t4_overflow", o_overflow, 136'd1);
    drain();
    retire(32'h400, 32'hE3A00002, 1'b1, 4'b1001);
    step();
    i_clr = 1'b1;
    step();
    i_clr = 1'b0;
    chk("t4_clr_drop", o_drop_cnt, 136'd0);
    chk("t4_clr_ovf", o_overflow, 136'd0);
    retire(32'h404, 32'hE3A00003, 1'b1, 4'b0001);
    step();

    // Full boundary: push and pop together at DEPTH.
    i_ready = 1'b0;
    for (int k = 0; k < 16; k++)
      retire(32'h500 + 32'(4*k), 32'hE2800000 + 32'(k), 1'b1, 4'b0001);
    chk("t5_full", o_count, 136'd16);
    i_ready = 1'b1;
    retire(32'h600, 32'hE2811001, 1'b1, 4'b0001);
    i_ready = 1'b0;
    chk("t5_count", o_count, 136'd16);
    chk("t5_drop", {o_overflow, o_drop_cnt}, 136'd0);
    drain();

    // Reset mid-operation discards queued records.
    i_ready = 1'b0;
    for (int k = 0; k < 5; k++)
      retire(32'h700 + 32'(4*k), 32'hE0000000 + 32'(k), 1'b1, 4'b0001);
    chk("t6_count5", o_count, 136'd5);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    exp_q.delete();
    chk("t6_valid", o_valid, 136'd0);
    chk("t6_count", o_count, 136'd0);
    chk("t6_fields", {o_flags, o_pc, o_instr, o_addr, o_data, o_be}, 136'd0);

    step();
    chk("sb_empty", 136'(exp_q.size()), 136'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
